// File: rtl/cmsdk_mcu_mtx_arb_param.sv
// Output-stage arbiter for the CMSDK bus matrix: fixed-priority or round-robin
// selection of the input port owning the address phase, with burst-aware grant holding.
module cmsdk_mcu_mtx_arb_param #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_W     = 2,
  parameter int ARB_MODE   = 0,
  parameter int BURST_HOLD = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 burst_hold
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  // Remaining beats after the first one of a fixed-length burst; zero for SINGLE/INCR.
  function automatic logic [3:0] burst_load(input logic [2:0] hburst);
    logic [3:0] len_m1;
    case (hburst)
      3'b010, 3'b011: len_m1 = 4'd3;
      3'b100, 3'b101: len_m1 = 4'd7;
      3'b110, 3'b111: len_m1 = 4'd15;
      default:        len_m1 = 4'd0;
    endcase
    return len_m1;
  endfunction

  logic [3:0]           beat_cnt_r;
  logic [3:0]           beat_cnt_s;
  logic [PORT_W-1:0]    rr_ptr_r;
  logic [PORT_W-1:0]    rr_next_s;
  logic [NUM_PORTS-1:0] eff_req_s;
  logic [PORT_W-1:0]    grant_fixed_s;
  logic [PORT_W-1:0]    grant_upper_s;
  logic [PORT_W-1:0]    grant_lower_s;
  logic                 upper_found_s;
  logic [PORT_W-1:0]    grant_rr_s;
  logic [PORT_W-1:0]    port_next_s;
  logic                 no_port_next_s;
  logic                 hold_burst_s;

  // Beat counter next value; anything unexpected clears it so an aborted burst cannot stall arbitration.
  always_comb begin
    beat_cnt_s = 4'd0;
    if (HSELM) begin
      case (HTRANSM)
        TRANS_NONSEQ: beat_cnt_s = burst_load(HBURSTM);
        TRANS_SEQ:    beat_cnt_s = (beat_cnt_r == 4'd0) ? 4'd0 : beat_cnt_r - 4'd1;
        TRANS_BUSY:   beat_cnt_s = beat_cnt_r;
        TRANS_IDLE:   beat_cnt_s = 4'd0;
        default:      beat_cnt_s = 4'd0;
      endcase
    end else begin
      beat_cnt_s = 4'd0;
    end
  end

  // Effective requests and both candidate grants.
  always_comb begin
    eff_req_s     = '0;
    grant_fixed_s = '0;
    grant_upper_s = '0;
    grant_lower_s = '0;
    upper_found_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eff_req_s[i] = req_port[i] |
                     ((addr_in_port == PORT_W'(i)) & HSELM & (HTRANSM != TRANS_IDLE));
    end
    // Downward scan so the lowest qualifying index is the one left standing.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      grant_fixed_s = eff_req_s[i] ? PORT_W'(i) : grant_fixed_s;
      grant_lower_s = eff_req_s[i] ? PORT_W'(i) : grant_lower_s;
      grant_upper_s = (eff_req_s[i] && (PORT_W'(i) > rr_ptr_r)) ? PORT_W'(i) : grant_upper_s;
      upper_found_s = upper_found_s | (eff_req_s[i] && (PORT_W'(i) > rr_ptr_r));
    end
    grant_rr_s = upper_found_s ? grant_upper_s : grant_lower_s;
  end

  // Next-state selection: lock, then burst hold, then arbitration, then park.
  always_comb begin
    hold_burst_s   = (BURST_HOLD != 0) && (beat_cnt_s != 4'd0);
    port_next_s    = addr_in_port;
    no_port_next_s = 1'b0;
    rr_next_s      = rr_ptr_r;
    if (HMASTLOCKM) begin
      no_port_next_s = 1'b0;
    end else if (hold_burst_s) begin
      no_port_next_s = 1'b0;
    end else if (eff_req_s != '0) begin
      port_next_s    = (ARB_MODE != 0) ? grant_rr_s : grant_fixed_s;
      rr_next_s      = port_next_s;
      no_port_next_s = 1'b0;
    end else if (HSELM) begin
      no_port_next_s = 1'b0;
    end else begin
      no_port_next_s = 1'b1;
    end
  end

  // State registers advance only when the output port completes a transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      burst_hold   <= 1'b0;
      beat_cnt_r   <= 4'd0;
      rr_ptr_r     <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      addr_in_port <= port_next_s;
      no_port      <= no_port_next_s;
      burst_hold   <= hold_burst_s;
      beat_cnt_r   <= beat_cnt_s;
      rr_ptr_r     <= rr_next_s;
    end else begin
      addr_in_port <= addr_in_port;
      no_port      <= no_port;
      burst_hold   <= burst_hold;
      beat_cnt_r   <= beat_cnt_r;
      rr_ptr_r     <= rr_ptr_r;
    end
  end

endmodule
